kim_muldiv_unit: RTL and testbench
==================================

# kim_muldiv_unit

Iterative multiply/divide unit for the 32-bit pipelined MIPS core, executing MULT, MULTU, DIV and DIVU and owning the architectural HI/LO registers. It sits beside the EX-stage ALU. Its `hi_out`/`lo_out` feed the EX result-select 2:1 muxes used for MFHI/MFLO. Its `busy` output drives the hazard unit, which stalls any MFHI, MFLO or new mult/div instruction.

## Interface
Parameters:
- `DATA_WIDTH`, 32: operand and HI/LO width. Only 32 is verified.

Ports:
- `clk`  in  1: rising-edge clock, single clock domain.
- `rst_n`  in  1: reset, synchronous, active-low.
- `start`  in  1: launch the operation selected by `op`. Accepted only in IDLE.
- `op`  in  2: operation select. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_data`  in  DATA_WIDTH: multiplicand or dividend.
- `rt_data`  in  DATA_WIDTH: multiplier or divisor.
- `mthi`  in  1: write `wdata` into HI.
- `mtlo`  in  1: write `wdata` into LO.
- `wdata`  in  DATA_WIDTH: MTHI/MTLO data.
- `flush`  in  1: abort any in-flight operation (branch/exception squash).
- `busy`  out  1: high while the state is RUN or FIX.
- `done`  out  1: one-cycle pulse after HI/LO are written by an operation.
- `hi_out`  out  DATA_WIDTH: current HI register.
- `lo_out`  out  DATA_WIDTH: current LO register.

## Operation
- Reset (`rst_n`=0 at an edge) forces:
  - state IDLE, iteration count 0;
  - HI = LO = 0;
  - `busy` = 0, `done` = 0.
- Reset overrides everything, including an operation in progress. No partial HI/LO update occurs.
- FSM has three states: IDLE, RUN, FIX.
- **IDLE**:
  - If `start`=1: latch operand magnitudes (absolute value for signed ops, raw value for unsigned), the result-sign flags, and `op`; clear the count; go to RUN.
  - `start` has priority. `mthi`/`mtlo` in the same cycle are dropped.
  - Otherwise, `mthi`/`mtlo` write HI/LO from `wdata` at that edge. Both may be asserted together.
- **RUN**: one iteration per edge, 32 iterations (count 0..31). After count 31, go to FIX.
  - Multiply: radix-2 shift-add on a 64-bit accumulator.
  - Divide: restoring shift-subtract; 32-bit remainder plus quotient shifted into the dividend register.
- **FIX**: apply sign correction, write HI/LO, set `done`=1 for the next cycle, return to IDLE.
  - Multiply: negate the 64-bit product if the operand signs differ. HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, negated if the operand signs differ. HI = remainder, carrying the sign of the dividend.
- Divide by zero (DIV or DIVU, `rt_data`=0): still runs full latency. Result is LO = 0xFFFFFFFF, HI = original `rs_data`. FIX substitutes these values explicitly.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This is the natural result mod 2^32; no trap.
- `start`, `mthi` and `mtlo` while `busy`=1 are ignored. HI/LO are untouched until FIX.
- `flush`=1 in RUN or FIX: go to IDLE at that edge. HI/LO are unchanged and no `done` is produced.
- `flush` in IDLE has no effect. `flush` in the same cycle as `start` in IDLE cancels the start.
- All arithmetic is unsigned on magnitudes. Signed handling happens only at latch (abs) and at FIX (negate).

## Timing
- Edge E0 is the edge that samples `start`=1 in IDLE.
  - RUN occupies edges E1..E32.
  - FIX writes HI/LO at edge E33.
- `busy` is high from after E0 until E33, i.e. 33 cycles.
- `done` is high for exactly the cycle between E33 and E34.
- `hi_out`/`lo_out` show the new values from that same `done` cycle.
- A back-to-back `start` can be accepted at E33+1 = E34 at the earliest, because the FSM is back in IDLE after E33.
- MTHI/MTLO latency is 1 cycle: the write at edge E shows on `hi_out`/`lo_out` after E.
- All outputs are registered or decoded purely from state. There is no combinational path from inputs to outputs.

## Structure
- Shared package `kim_pip_pkg` holds:
  - the `op` encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the FSM state enum (ST_IDLE, ST_RUN, ST_FIX);
  - the iteration count constant (32).
- One sub-module, `kim_cond_neg`: a parameterised conditional two's-complement negate (`neg`, `in`, `out`).
  - Instantiated for operand abs at 32 bits, quotient/remainder correction at 32 bits, and product correction at 64 bits.
- The datapath and FSM live in `kim_muldiv_unit` itself.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. `busy` high exactly 33 cycles; `done` one cycle, 34 cycles after E0.
- MULT −3 (0xFFFFFFFD) × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then, back-to-back at E34, DIVU 100 / 7 → LO=0x0000000E, HI=0x00000002.
- Divide edge cases:
  - DIVU 0x1234 / 0 → LO=0xFFFFFFFF, HI=0x00001234.
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI 0xAAAA, then MULT, with `flush` at RUN cycle 10 → HI stays 0xAAAA, `busy` low after that edge, no `done`. Also `mtlo` and `start` pulsed while busy → ignored, LO unchanged.
- Reset mid-operation: `rst_n`=0 at RUN cycle 20 → HI=LO=0, `busy`=0, `done`=0. A new MULTU 6 × 7 after reset → LO=42, HI=0.

Source files
------------

// File: rtl/kim_pip_pkg.sv
// rtl/kim_pip_pkg.sv - shared op encodings, FSM states and iteration constants
package kim_pip_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_t;

  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = $clog2(ITER_COUNT);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);

endpackage

// File: rtl/kim_cond_neg.sv
// rtl/kim_cond_neg.sv - conditional two's-complement negate
module kim_cond_neg #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  // Negate when requested, otherwise pass through unchanged
  always_comb begin
    out = neg ? (~in + WIDTH'(1)) : in;
  end

endmodule

// File: rtl/kim_muldiv_unit.sv
// rtl/kim_muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI/LO
module kim_muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  input  logic                  mthi,
  input  logic                  mtlo,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out
);

  import kim_pip_pkg::*;

  localparam int W  = DATA_WIDTH;
  localparam int W2 = 2 * DATA_WIDTH;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       op_q, op_d;
  // Multiply: {partial product, remaining multiplier}. Divide: {remainder, quotient/dividend}.
  logic [W2-1:0]    acc_q, acc_d;
  // Multiplicand magnitude for multiply, divisor magnitude for divide
  logic [W-1:0]     opb_q, opb_d;
  logic [W-1:0]     rs_q, rs_d;
  logic             sign_x_q, sign_x_d;
  logic             sign_a_q, sign_a_d;
  logic             div0_q, div0_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;
  logic             done_q, done_d;

  logic [W-1:0]  abs_rs, abs_rt;
  logic [W2-1:0] prod_fix;
  logic [W-1:0]  quot_fix, rem_fix;
  logic          op_signed_q;
  logic [W:0]    mul_sum;
  logic [W:0]    div_trial;
  logic [W2-1:0] mul_next, div_next;

  assign op_signed_q = ~op_q[0];

  kim_cond_neg #(.WIDTH(W)) u_abs_rs (
    .neg (~op[0] & rs_data[W-1]),
    .in  (rs_data),
    .out (abs_rs)
  );

  kim_cond_neg #(.WIDTH(W)) u_abs_rt (
    .neg (~op[0] & rt_data[W-1]),
    .in  (rt_data),
    .out (abs_rt)
  );

  kim_cond_neg #(.WIDTH(W2)) u_fix_prod (
    .neg (op_signed_q & sign_x_q),
    .in  (acc_q),
    .out (prod_fix)
  );

  kim_cond_neg #(.WIDTH(W)) u_fix_quot (
    .neg (op_signed_q & sign_x_q),
    .in  (acc_q[W-1:0]),
    .out (quot_fix)
  );

  kim_cond_neg #(.WIDTH(W)) u_fix_rem (
    .neg (op_signed_q & sign_a_q),
    .in  (acc_q[W2-1:W]),
    .out (rem_fix)
  );

  // One shift-add or restoring shift-subtract step on the accumulator
  always_comb begin
    mul_sum   = {1'b0, acc_q[W2-1:W]} + {1'b0, (acc_q[0] ? opb_q : {W{1'b0}})};
    mul_next  = {mul_sum, acc_q[W-1:1]};
    div_trial = {acc_q[W2-1:W], acc_q[W-1]} - {1'b0, opb_q};
    if (!div_trial[W]) begin
      div_next = {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
    end else begin
      div_next = {acc_q[W2-2:0], 1'b0};
    end
  end

  // Next-state and datapath update for IDLE / RUN / FIX
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    rs_d     = rs_q;
    sign_x_d = sign_x_q;
    sign_a_d = sign_a_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (!flush) begin
            op_d     = op;
            count_d  = '0;
            opb_d    = op[1] ? abs_rt : abs_rs;
            acc_d    = {{W{1'b0}}, (op[1] ? abs_rs : abs_rt)};
            rs_d     = rs_data;
            sign_x_d = rs_data[W-1] ^ rt_data[W-1];
            sign_a_d = rs_data[W-1];
            div0_d   = (rt_data == {W{1'b0}});
            state_d  = ST_RUN;
          end
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d   = op_q[1] ? div_next : mul_next;
          count_d = count_q + CNT_W'(1);
          if (count_q == LAST_ITER) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (!op_q[1]) begin
            hi_d = prod_fix[W2-1:W];
            lo_d = prod_fix[W-1:0];
          end else if (div0_q) begin
            hi_d = rs_q;
            lo_d = {W{1'b1}};
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and architectural registers; reset clears HI/LO and aborts any operation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      op_q     <= OP_MULT;
      acc_q    <= '0;
      opb_q    <= '0;
      rs_q     <= '0;
      sign_x_q <= 1'b0;
      sign_a_q <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      rs_q     <= rs_d;
      sign_x_q <= sign_x_d;
      sign_a_q <= sign_a_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_kim_muldiv_unit.sv
// tb/tb_kim_muldiv_unit.sv - directed self-checking bench for kim_muldiv_unit
module tb_kim_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int errors = 0;
  int checks = 0;

  kim_muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .wdata   (wdata),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .hi_out  (hi_out),
    .lo_out  (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int busy_cnt, output int done_at);
    busy_cnt = 0;
    done_at  = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_at = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (hi_out !== 32'h0 || lo_out !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b expected all zero", hi_out, lo_out, busy, done);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_multu;
    int bc, da;
    @(negedge clk);
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(bc, da);
    checks++;
    if (bc !== 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d expected 33", bc); end
    checks++;
    if (da !== 34) begin errors++; $display("FAIL multu_done_cycle: got %0d expected 34", da); end
    checks++;
    if (hi_out !== 32'hFFFF_FFFE || lo_out !== 32'h0000_0001) begin
      errors++; $display("FAIL multu_result: got hi=%h lo=%h expected hi=fffffffe lo=00000001", hi_out, lo_out);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL multu_done_pulse: got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_mult;
    int bc, da;
    @(negedge clk);
    launch(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done(bc, da);
    checks++;
    if (hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFEB || da !== 34) begin
      errors++; $display("FAIL mult_neg: got hi=%h lo=%h done_at=%0d expected ffffffff ffffffeb 34", hi_out, lo_out, da);
    end
  endtask

  task automatic test_back_to_back;
    int bc, da;
    @(negedge clk);
    launch(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(bc, da);
    checks++;
    if (hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFFD || da !== 34) begin
      errors++; $display("FAIL div_neg: got hi=%h lo=%h done_at=%0d expected ffffffff fffffffd 34", hi_out, lo_out, da);
    end
    launch(2'b11, 32'd100, 32'd7);
    wait_done(bc, da);
    checks++;
    if (hi_out !== 32'h0000_0002 || lo_out !== 32'h0000_000E || da !== 34 || bc !== 33) begin
      errors++; $display("FAIL divu_b2b: got hi=%h lo=%h done_at=%0d busy=%0d expected 2 e 34 33", hi_out, lo_out, da, bc);
    end
  endtask

  task automatic test_div_edge;
    int bc, da;
    @(negedge clk);
    launch(2'b11, 32'h0000_1234, 32'h0);
    wait_done(bc, da);
    checks++;
    if (hi_out !== 32'h0000_1234 || lo_out !== 32'hFFFF_FFFF || da !== 34) begin
      errors++; $display("FAIL divu_by_zero: got hi=%h lo=%h done_at=%0d expected 00001234 ffffffff 34", hi_out, lo_out, da);
    end
    @(negedge clk);
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(bc, da);
    checks++;
    if (hi_out !== 32'h0 || lo_out !== 32'h8000_0000) begin
      errors++; $display("FAIL div_overflow: got hi=%h lo=%h expected 00000000 80000000", hi_out, lo_out);
    end
  endtask

  task automatic test_flush_ignore;
    int dcnt;
    @(negedge clk);
    mthi = 1'b1; wdata = 32'h0000_AAAA;
    @(posedge clk); #1;
    mthi = 1'b0;
    @(negedge clk);
    checks++;
    if (hi_out !== 32'h0000_AAAA || lo_out !== 32'h8000_0000) begin
      errors++; $display("FAIL mthi_write: got hi=%h lo=%h expected 0000aaaa 80000000", hi_out, lo_out);
    end
    launch(2'b00, 32'd5, 32'd3);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 5) begin
        mtlo = 1'b1; wdata = 32'h0000_5555; start = 1'b1; op = 2'b01;
      end else if (i == 6) begin
        mtlo = 1'b0; start = 1'b0;
      end
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_before_flush: got %b expected 1", busy); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_flush: got %b expected 0", busy); end
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    checks++;
    if (dcnt !== 0 || hi_out !== 32'h0000_AAAA || lo_out !== 32'h8000_0000) begin
      errors++; $display("FAIL flush_result: got done_count=%0d hi=%h lo=%h expected 0 0000aaaa 80000000", dcnt, hi_out, lo_out);
    end
    start = 1'b1; flush = 1'b1; op = 2'b01;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_flush_cancels_start: got busy=%b expected 0", busy); end
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_1357;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    @(negedge clk);
    checks++;
    if (hi_out !== 32'h0000_1357 || lo_out !== 32'h0000_1357) begin
      errors++; $display("FAIL mthi_mtlo_both: got hi=%h lo=%h expected 00001357 00001357", hi_out, lo_out);
    end
  endtask

  task automatic test_reset_mid;
    int bc, da;
    @(negedge clk);
    launch(2'b01, 32'h0001_2345, 32'h0000_0678);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (hi_out !== 32'h0 || lo_out !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_mid_op: got hi=%h lo=%h busy=%b done=%b expected all zero", hi_out, lo_out, busy, done);
    end
    launch(2'b01, 32'd6, 32'd7);
    wait_done(bc, da);
    checks++;
    if (hi_out !== 32'h0 || lo_out !== 32'd42 || da !== 34) begin
      errors++; $display("FAIL multu_after_reset: got hi=%h lo=%h done_at=%0d expected 0 0000002a 34", hi_out, lo_out, da);
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_back_to_back();
    test_div_edge();
    test_flush_ignore();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
